// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - shares one req/gnt/rvalid memory port between Ibex fetch and data
//
// Purpose: arbitrates the instruction-fetch and data request interfaces of the
// core onto a single memory port. The address phase of the selected source is
// locked until it is granted. The granted source IDs are kept in an in-order
// FIFO so that every response is routed back to the source that issued it.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   instr_*                fetch request/grant/response (read-only, full word)
//   data_*                 data request/grant/response (we, be, wdata)
//   mem_*                  shared downstream port
//   unexpected_rvalid_o    mem_rvalid_i seen with nothing outstanding
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        unexpected_rvalid_o
);

  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] CntMax  = CW'(MaxOutstanding);
  localparam logic [PW-1:0] PtrLast = PW'(MaxOutstanding - 1);

  // Source ID FIFO: 0 = instr, 1 = data.
  logic          r_ids [MaxOutstanding];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  logic r_lock;       // selection held because the last request was not granted
  logic r_lock_data;  // selection captured for the lock
  logic r_pref_data;  // round-robin preference when both sources request

  logic w_sel_data;
  logic w_sel_req;
  logic w_full;
  logic w_mem_req;
  logic w_grant;
  logic w_pop;
  logic w_head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_sel_data = 1'b0;
    if (r_lock) begin
      w_sel_data = r_lock_data;
    end else if (DataPriority) begin
      w_sel_data = data_req_i;
    end else if (instr_req_i && data_req_i) begin
      w_sel_data = r_pref_data;
    end else begin
      w_sel_data = data_req_i;
    end
  end

  assign w_sel_req   = w_sel_data ? data_req_i : instr_req_i;
  assign w_full      = (r_cnt == CntMax);
  // Outputs are forced low while rst_ni is asserted, including the
  // combinational pass-through paths.
  assign w_mem_req   = rst_ni && w_sel_req && !w_full;
  assign w_grant     = w_mem_req && mem_gnt_i;
  assign w_pop       = rst_ni && mem_rvalid_i && (r_cnt != '0);
  assign w_head_data = r_ids[r_rptr];

  assign mem_req_o   = w_mem_req;
  assign instr_gnt_o = w_grant && !w_sel_data;
  assign data_gnt_o  = w_grant && w_sel_data;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (w_mem_req) begin
      if (w_sel_data) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_rvalid_o      = w_pop && !w_head_data;
  assign data_rvalid_o       = w_pop && w_head_data;
  assign instr_rdata_o       = rst_ni ? mem_rdata_i : 32'h0;
  assign data_rdata_o        = rst_ni ? mem_rdata_i : 32'h0;
  assign instr_err_o         = rst_ni && mem_err_i;
  assign data_err_o          = rst_ni && mem_err_i;
  assign unexpected_rvalid_o = rst_ni && mem_rvalid_i && (r_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_lock      <= 1'b0;
      r_lock_data <= 1'b0;
      r_pref_data <= 1'b1;
    end else begin
      r_lock      <= w_mem_req && !mem_gnt_i;
      r_lock_data <= w_sel_data;
      if (w_grant) begin
        r_wptr      <= ptr_inc(r_wptr);
        r_pref_data <= !w_sel_data;
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_grant, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ID storage needs no reset; validity is tracked by r_cnt.
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_ids[r_wptr] <= w_sel_data;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb/tb_ibex_mem_arbiter.sv - scoreboard bench for ibex_mem_arbiter
module tb_ibex_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = 32'h0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;

  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_rdata;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we, unexp;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;

  logic        p_instr_gnt, p_instr_rvalid, p_instr_err;
  logic [31:0] p_instr_rdata;
  logic        p_data_gnt, p_data_rvalid, p_data_err;
  logic [31:0] p_data_rdata;
  logic        p_mem_req, p_mem_we, p_unexp;
  logic [3:0]  p_mem_be;
  logic [31:0] p_mem_addr, p_mem_wdata;

  always #5 clk = ~clk;

  ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .unexpected_rvalid_o(unexp)
  );

  ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_prio (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(p_instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(p_instr_rvalid), .instr_rdata_o(p_instr_rdata), .instr_err_o(p_instr_err),
    .data_req_i(data_req), .data_gnt_o(p_data_gnt), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rvalid_o(p_data_rvalid), .data_rdata_o(p_data_rdata), .data_err_o(p_data_err),
    .mem_req_o(p_mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(p_mem_we), .mem_be_o(p_mem_be),
    .mem_addr_o(p_mem_addr), .mem_wdata_o(p_mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .unexpected_rvalid_o(p_unexp)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic sb_q[$];  // expected response source order: 0 = instr, 1 = data

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic dreq, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic er);
    instr_req  = ireq;
    data_req   = dreq;
    mem_gnt    = gnt;
    mem_rvalid = rv;
    mem_rdata  = rd;
    mem_err    = er;
  endtask

  task automatic chk_resp(input string tag);
    logic src;
    if (!mem_rvalid) begin
      check_eq({tag, ".irv"}, instr_rvalid, 1'b0);
      check_eq({tag, ".drv"}, data_rvalid, 1'b0);
      check_eq({tag, ".unx"}, unexp, 1'b0);
    end else if (sb_q.size() == 0) begin
      check_eq({tag, ".unx"}, unexp, 1'b1);
      check_eq({tag, ".irv"}, instr_rvalid, 1'b0);
      check_eq({tag, ".drv"}, data_rvalid, 1'b0);
    end else begin
      src = sb_q.pop_front();
      check_eq({tag, ".unx"}, unexp, 1'b0);
      check_eq({tag, ".irv"}, instr_rvalid, !src);
      check_eq({tag, ".drv"}, data_rvalid, src);
      if (src) begin
        check_eq({tag, ".drd"}, data_rdata, mem_rdata);
        check_eq({tag, ".der"}, data_err, mem_err);
      end else begin
        check_eq({tag, ".ird"}, instr_rdata, mem_rdata);
        check_eq({tag, ".ier"}, instr_err, mem_err);
      end
    end
  endtask

  // exp_gnt: 0 = instr granted, 1 = data granted, 2 = no grant this cycle.
  task automatic step(input string tag, input logic ireq, input logic dreq, input logic gnt,
                      input logic rv, input logic [31:0] rd, input logic er,
                      input int exp_gnt, input logic exp_mreq, input logic [31:0] exp_addr,
                      input bit prio_chk);
    drive(ireq, dreq, gnt, rv, rd, er);
    @(negedge clk);
    chk_resp(tag);
    check_eq({tag, ".mreq"}, mem_req, exp_mreq);
    check_eq({tag, ".addr"}, mem_addr, exp_addr);
    check_eq({tag, ".ignt"}, instr_gnt, exp_gnt == 0);
    check_eq({tag, ".dgnt"}, data_gnt, exp_gnt == 1);
    if (exp_gnt == 0) begin
      check_eq({tag, ".we"}, mem_we, 1'b0);
      check_eq({tag, ".be"}, mem_be, 4'hF);
      check_eq({tag, ".wd"}, mem_wdata, 32'h0);
      sb_q.push_back(1'b0);
    end else if (exp_gnt == 1) begin
      check_eq({tag, ".we"}, mem_we, data_we);
      check_eq({tag, ".be"}, mem_be, data_be);
      check_eq({tag, ".wd"}, mem_wdata, data_wdata);
      sb_q.push_back(1'b1);
    end
    if (prio_chk) begin
      check_eq({tag, ".pdgnt"}, p_data_gnt, 1'b1);
      check_eq({tag, ".pignt"}, p_instr_gnt, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1);
    @(negedge clk);
    check_eq("rst.mreq", mem_req, 1'b0);
    check_eq("rst.ignt", instr_gnt, 1'b0);
    check_eq("rst.dgnt", data_gnt, 1'b0);
    check_eq("rst.irv", instr_rvalid, 1'b0);
    check_eq("rst.drv", data_rvalid, 1'b0);
    check_eq("rst.unx", unexp, 1'b0);
    check_eq("rst.addr", mem_addr, 32'h0);
    check_eq("rst.ird", instr_rdata, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    sb_q.delete();
  endtask

  initial begin
    do_reset();

    // single fetch, response next cycle
    instr_addr = 32'h100;
    step("t1.g", 1, 0, 1, 0, 32'h0, 0, 0, 1, 32'h100, 0);
    step("t1.r", 0, 0, 0, 1, 32'hDEADBEEF, 0, 2, 0, 32'h0, 0);

    // continuous contention: RR alternates from data; priority instance always data
    do_reset();
    instr_addr = 32'h1000; data_addr = 32'h2000; data_we = 1; data_be = 4'h5; data_wdata = 32'h77;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("t2.%0d", i), 1, 1, 1, i > 0, 32'hA0 + i, 0, i % 2 == 0 ? 1 : 0, 1,
           i % 2 == 0 ? 32'h2000 : 32'h1000, 1);
    end
    step("t2.drain", 0, 0, 0, 1, 32'hA9, 0, 2, 0, 32'h0, 0);

    // lock: data stalls 3 cycles while instr has the RR preference
    do_reset();
    instr_addr = 32'h300; data_addr = 32'h200; data_we = 1; data_be = 4'h3; data_wdata = 32'hCAFE;
    step("t3.pre", 0, 1, 1, 0, 32'h0, 0, 1, 1, 32'h200, 0);
    step("t3.prer", 0, 0, 0, 1, 32'hB0, 0, 2, 0, 32'h0, 0);
    step("t3.s1", 0, 1, 0, 0, 32'h0, 0, 2, 1, 32'h200, 0);
    step("t3.s2", 1, 1, 0, 0, 32'h0, 0, 2, 1, 32'h200, 0);
    step("t3.s3", 1, 1, 0, 0, 32'h0, 0, 2, 1, 32'h200, 0);
    step("t3.g", 1, 1, 1, 0, 32'h0, 0, 1, 1, 32'h200, 0);
    step("t3.i", 1, 1, 1, 1, 32'hB1, 0, 0, 1, 32'h300, 0);
    step("t3.r", 0, 0, 0, 1, 32'hB2, 0, 2, 0, 32'h0, 0);

    // outstanding limit and simultaneous push/pop
    do_reset();
    instr_addr = 32'h400; data_addr = 32'h500; data_we = 0; data_be = 4'hF; data_wdata = 32'h1;
    step("t4.c1", 1, 0, 1, 0, 32'h0, 0, 0, 1, 32'h400, 0);
    step("t4.c2", 0, 1, 1, 1, 32'hA1, 0, 1, 1, 32'h500, 0);
    step("t4.c3", 1, 0, 1, 0, 32'h0, 0, 0, 1, 32'h400, 0);
    step("t4.full", 1, 1, 1, 0, 32'h0, 0, 2, 0, 32'h0, 0);
    step("t4.fullrv", 1, 1, 1, 1, 32'hA2, 0, 2, 0, 32'h0, 0);
    step("t4.c6", 1, 1, 1, 1, 32'hA3, 0, 1, 1, 32'h500, 0);
    step("t4.c7", 0, 0, 0, 1, 32'hA4, 0, 2, 0, 32'h0, 0);

    // in-order responses with error on the second
    do_reset();
    step("t5.gi", 1, 0, 1, 0, 32'h0, 0, 0, 1, 32'h400, 0);
    step("t5.gd", 0, 1, 1, 0, 32'h0, 0, 1, 1, 32'h500, 0);
    step("t5.r1", 0, 0, 0, 1, 32'h55, 0, 2, 0, 32'h0, 0);
    step("t5.r2", 0, 0, 0, 1, 32'h66, 1, 2, 0, 32'h0, 0);

    // unexpected responses: idle, and after a mid-burst reset
    do_reset();
    step("t6.unx0", 0, 0, 0, 1, 32'h1, 0, 2, 0, 32'h0, 0);
    step("t6.gi", 1, 0, 1, 0, 32'h0, 0, 0, 1, 32'h400, 0);
    step("t6.gd", 0, 1, 1, 0, 32'h0, 0, 1, 1, 32'h500, 0);
    do_reset();
    step("t6.late1", 0, 0, 0, 1, 32'h2, 0, 2, 0, 32'h0, 0);
    step("t6.late2", 0, 0, 0, 1, 32'h3, 1, 2, 0, 32'h0, 0);
    step("t6.idle", 0, 0, 0, 0, 32'h0, 0, 2, 0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
